// File: rtl/cpu_controller_pkg.sv
// Shared types for the accumulator-CPU instruction sequencer: opcodes, FSM states,
// the packed control vector, and the ALU-opcode classifier.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_e;

    // Phase states are numbered so their low 3 bits equal the reported phase index.
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } ctrl_state_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic data_e;
        logic wr;
        logic halt;
    } ctrl_t;

    function automatic logic is_aluop(input opcode_e op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Control bus between the sequencer (master) and the CPU datapath (slave):
// opcode/zero flow into the controller, strobes flow out.
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       data_e;
    logic       wr;
    logic       halt;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
    );
endinterface

// File: rtl/cpu_controller_decode.sv
// Pure combinational decode of (state, opcode, zero) into the control strobe vector.
module ctrl_decode
    import cpu_pkg::*;
(
    input  ctrl_state_e state,
    input  opcode_e     opcode,
    input  logic        zero,
    output ctrl_t       ctrl
);

    logic aluop;

    always_comb begin
        ctrl  = '0;
        aluop = is_aluop(opcode);
        unique case (state)
            INST_ADDR: begin
                ctrl.sel = 1'b1;
            end
            INST_FETCH: begin
                ctrl.sel = 1'b1;
                ctrl.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                ctrl.sel   = 1'b1;
                ctrl.rd    = 1'b1;
                ctrl.ld_ir = 1'b1;
            end
            OP_ADDR: begin
                ctrl.inc_pc = 1'b1;
                ctrl.halt   = (opcode == HLT);
            end
            OP_FETCH: begin
                ctrl.rd = aluop;
            end
            ALU_OP: begin
                // zero only matters here: it decides whether SKZ skips the next word.
                ctrl.rd     = aluop;
                ctrl.inc_pc = (opcode == SKZ) && zero;
                ctrl.ld_pc  = (opcode == JMP);
                ctrl.data_e = (opcode == STO);
            end
            STORE: begin
                ctrl.rd     = aluop;
                ctrl.ld_ac  = aluop;
                ctrl.inc_pc = (opcode == JMP);
                ctrl.ld_pc  = (opcode == JMP);
                ctrl.data_e = (opcode == STO);
                ctrl.wr     = (opcode == STO);
            end
            HALTED: begin
                ctrl.halt = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: state register, optional single-step gating
// (CTRL_STEP_EN adds the step port) and the retired-instruction counter.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CTRL_STEP_EN
    input  logic             step,
`endif
    cpu_controller_if.master bus,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_cnt
);

    ctrl_state_e      state_reg;
    ctrl_state_e      state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    ctrl_t            ctrl;
    logic             start_ok;

`ifdef CTRL_STEP_EN
    assign start_ok = step;
`else
    assign start_ok = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            INST_ADDR:  state_next = start_ok ? INST_FETCH : INST_ADDR;
            INST_FETCH: state_next = INST_LOAD;
            INST_LOAD:  state_next = IDLE;
            IDLE:       state_next = OP_ADDR;
            OP_ADDR:    state_next = (opcode_e'(bus.opcode) == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_next = ALU_OP;
            ALU_OP:     state_next = STORE;
            STORE: begin
                state_next = INST_ADDR;
                cnt_next   = cnt_reg + CNT_W'(1);
            end
            HALTED:     state_next = HALTED;
            default:    state_next = INST_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= INST_ADDR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    ctrl_decode u_decode (
        .state  (state_reg),
        .opcode (opcode_e'(bus.opcode)),
        .zero   (bus.zero),
        .ctrl   (ctrl)
    );

    assign bus.sel    = ctrl.sel;
    assign bus.rd     = ctrl.rd;
    assign bus.ld_ir  = ctrl.ld_ir;
    assign bus.inc_pc = ctrl.inc_pc;
    assign bus.ld_pc  = ctrl.ld_pc;
    assign bus.ld_ac  = ctrl.ld_ac;
    assign bus.data_e = ctrl.data_e;
    assign bus.wr     = ctrl.wr;
    assign bus.halt   = ctrl.halt;

    // HALTED sits outside the 0..7 numbering and reports as phase 7.
    assign phase     = (state_reg == HALTED) ? 3'd7 : state_reg[2:0];
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller (4-bit counter instance); define CTRL_STEP_EN
// for the single-step scenarios.
module tb_cpu_controller;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instr_cnt;
`ifdef CTRL_STEP_EN
    logic             step;
`endif

    int total;
    int bad;
    logic [CNT_W-1:0] exp_cnt;

    cpu_controller_if bus ();

    cpu_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CTRL_STEP_EN
        .step      (step),
`endif
        .bus       (bus),
        .phase     (phase),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.ld_ac, bus.data_e, bus.wr, bus.halt};
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.opcode = 3'b000;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (phase !== 3'd0 || outs() !== 9'b1_0000_0000 || instr_cnt !== '0) begin
            bad++;
            $display("FAIL reset: phase=%0d outs=%b cnt=%0d, required phase=0 outs=100000000 cnt=0",
                     phase, outs(), instr_cnt);
        end else
            $display("reset ok: phase=%0d outs=%b cnt=%0d", phase, outs(), instr_cnt);
        exp_cnt = '0;
    endtask

    // Runs one instruction from INST_ADDR; masks give the expected bit per phase (bit p = phase p).
    task automatic test_opcode(input string name, input logic [2:0] opc, input logic z,
                               input logic [7:0] m_rd, input logic [7:0] m_inc,
                               input logic [7:0] m_ldpc, input logic [7:0] m_ldac,
                               input logic [7:0] m_de, input logic [7:0] m_wr);
        logic [7:0] m_sel;
        logic [7:0] m_ldir;
        logic [8:0] exp;
        m_sel  = 8'b0000_1111;
        m_ldir = 8'b0000_1100;
        for (int p = 0; p < 8; p++) begin
            bus.opcode = opc;
            bus.zero   = (p == 6) ? z : ~z;
            #1;
            exp = {m_sel[p], m_rd[p], m_ldir[p], m_inc[p], m_ldpc[p],
                   m_ldac[p], m_de[p], m_wr[p], 1'b0};
            total++;
            if (phase !== 3'(p) || outs() !== exp) begin
                bad++;
                $display("FAIL %s p%0d: phase=%0d outs=%b, required phase=%0d outs=%b",
                         name, p, phase, outs(), p, exp);
            end
            @(posedge clk);
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 1'b1;
        #1;
        total++;
        if (phase !== 3'd0 || instr_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL %s retire: phase=%0d cnt=%0d, required phase=0 cnt=%0d",
                     name, phase, instr_cnt, exp_cnt);
        end else
            $display("%s done: cnt=%0d", name, instr_cnt);
    endtask

    task automatic test_abort();
        bus.opcode = 3'b010;
        repeat (5) begin
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_cnt = '0;
        total++;
        if (phase !== 3'd0 || outs() !== 9'b1_0000_0000 || instr_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL abort: phase=%0d outs=%b cnt=%0d, required phase=0 outs=100000000 cnt=0",
                     phase, outs(), instr_cnt);
        end else
            $display("abort ok: phase=%0d cnt=%0d", phase, instr_cnt);
    endtask

    task automatic test_halt();
        bus.opcode = 3'b000;
        bus.zero   = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (phase !== 3'd4 || outs() !== 9'b0_0010_0001) begin
            bad++;
            $display("FAIL halt op_addr: phase=%0d outs=%b, required phase=4 outs=000100001",
                     phase, outs());
        end
        for (int i = 0; i < 5; i++) begin
            bus.zero = i[0];
            @(posedge clk);
            @(negedge clk);
            #1;
            total++;
            if (phase !== 3'd7 || outs() !== 9'b0_0000_0001 || instr_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL halted c%0d: phase=%0d outs=%b cnt=%0d, required phase=7 outs=000000001 cnt=%0d",
                         i, phase, outs(), instr_cnt, exp_cnt);
            end else
                $display("halted c%0d: phase=%0d cnt=%0d", i, phase, instr_cnt);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_cnt = '0;
        total++;
        if (phase !== 3'd0 || outs() !== 9'b1_0000_0000 || instr_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL halt reset: phase=%0d outs=%b cnt=%0d, required phase=0 outs=100000000 cnt=0",
                     phase, outs(), instr_cnt);
        end else
            $display("halt reset ok: phase=%0d cnt=%0d", phase, instr_cnt);
    endtask

`ifdef CTRL_STEP_EN
    task automatic test_step();
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            total++;
            if (phase !== 3'd0 || outs() !== 9'b1_0000_0000) begin
                bad++;
                $display("FAIL stall c%0d: phase=%0d outs=%b, required phase=0 outs=100000000",
                         i, phase, outs());
            end
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (phase !== 3'd0) begin
            bad++;
            $display("FAIL stall after reset: phase=%0d, required 0", phase);
        end
        bus.opcode = 3'b010;
        step = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step = 1'b0;
        for (int p = 1; p < 8; p++) begin
            #1;
            total++;
            if (phase !== 3'(p)) begin
                bad++;
                $display("FAIL step run p%0d: phase=%0d, required %0d", p, phase, p);
            end
            @(posedge clk);
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (phase !== 3'd0 || instr_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL step hold c%0d: phase=%0d cnt=%0d, required phase=0 cnt=%0d",
                         i, phase, instr_cnt, exp_cnt);
            end else
                $display("step hold c%0d: phase=%0d cnt=%0d", i, phase, instr_cnt);
            @(posedge clk);
            @(negedge clk);
        end
        step = 1'b1;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
`ifdef CTRL_STEP_EN
        step = 1'b1;
`endif
        test_reset();
        //                 name   opc     z     rd           inc          ld_pc        ld_ac        data_e       wr
        test_opcode("ADD",  3'b010, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000);
        test_opcode("STO",  3'b110, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b1100_0000, 8'b1000_0000);
        test_opcode("SKZ1", 3'b001, 1'b1, 8'b0000_1110, 8'b0101_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        test_opcode("SKZ0", 3'b001, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        test_opcode("JMP",  3'b111, 1'b0, 8'b0000_1110, 8'b1001_0000, 8'b1100_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        test_opcode("AND",  3'b011, 1'b1, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000);
        test_opcode("XOR",  3'b100, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000);
        test_opcode("LDA",  3'b101, 1'b1, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000);
        test_abort();
        for (int i = 0; i < 16; i++)
            test_opcode("WRAP", 3'b010, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000);
        total++;
        if (instr_cnt !== 4'd0) begin
            bad++;
            $display("FAIL wrap: cnt=%0d, required 0", instr_cnt);
        end else
            $display("wrap ok: cnt=%0d", instr_cnt);
        test_halt();
`ifdef CTRL_STEP_EN
        test_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
